// File: rtl/mem_arb_defs_pkg.sv
// rtl/mem_arb_defs_pkg.sv - shared encodings and constants for the memory port arbiter
package mem_arb_defs;

  // Top-level sequencing: LOAD while the boot loader owns the port, RUN afterwards.
  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_t;

  // Which requester the read data returning next cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  // Load address of the boot image.
  localparam logic [31:0] BOOT_BASE = 32'h8002_0000;

  // Width of the fetch starvation counter; holds limits up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - combinational fixed-priority grant with fetch starvation guard
module mem_arb_prio
  import mem_arb_defs::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  arb_state_t       i_state,
  input  logic             i_fetch_req,
  input  logic             i_data_req,
  input  logic [CNT_W-1:0] i_starve_cnt,
  output logic             o_fetch_gnt,
  output logic             o_data_gnt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // Data wins a conflict unless fetch has already lost LIMIT times in a row.
  always_comb begin
    o_fetch_gnt = 1'b0;
    o_data_gnt  = 1'b0;
    if (i_state == ST_RUN) begin
      if (i_fetch_req && i_data_req) begin
        if (i_starve_cnt >= LIMIT) begin
          o_fetch_gnt = 1'b1;
        end else begin
          o_data_gnt = 1'b1;
        end
      end else begin
        o_fetch_gnt = i_fetch_req;
        o_data_gnt  = i_data_req;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one mem_controller port between loader, fetch and data stage
module mem_port_arbiter
  import mem_arb_defs::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [0:ADDR_W-1] i_load_addr,
  input  logic              i_load_wren,
  input  logic [0:DATA_W-1] i_load_wdata,
  input  logic              i_load_done,
  input  logic              i_fetch_req,
  input  logic [0:ADDR_W-1] i_fetch_addr,
  output logic              o_fetch_gnt,
  output logic              o_fetch_stall,
  output logic              o_fetch_rvalid,
  output logic [0:DATA_W-1] o_fetch_rdata,
  input  logic              i_data_req,
  input  logic              i_data_wren,
  input  logic [0:ADDR_W-1] i_data_addr,
  input  logic [0:DATA_W-1] i_data_wdata,
  output logic              o_data_gnt,
  output logic              o_data_rvalid,
  output logic [0:DATA_W-1] o_data_rdata,
  output logic [0:ADDR_W-1] o_mem_address,
  output logic              o_mem_wren,
  output logic [0:DATA_W-1] o_mem_data_in,
  input  logic [0:DATA_W-1] i_mem_data_out
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [CNT_W-1:0]  w_starve_nxt;
  owner_t            r_owner;
  owner_t            w_owner_nxt;
  logic [0:DATA_W-1] r_fetch_rdata;
  logic [0:DATA_W-1] r_data_rdata;
  logic              w_fetch_gnt;
  logic              w_data_gnt;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .i_state     (r_state),
    .i_fetch_req (i_fetch_req),
    .i_data_req  (i_data_req),
    .i_starve_cnt(r_starve_cnt),
    .o_fetch_gnt (w_fetch_gnt),
    .o_data_gnt  (w_data_gnt)
  );

  assign o_fetch_gnt   = w_fetch_gnt;
  assign o_data_gnt    = w_data_gnt;
  assign o_fetch_stall = (r_state == ST_LOAD) | (i_fetch_req & ~w_fetch_gnt);

  // State register: LOAD until the loader signals done, then RUN until reset.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: load_done only matters while still loading.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_LOAD && i_load_done) begin
      w_state_nxt = ST_RUN;
    end
  end

  // Port mux: loader owns the port in LOAD; otherwise the granted requester, else idle zeros.
  always_comb begin
    o_mem_address = '0;
    o_mem_wren    = 1'b0;
    o_mem_data_in = '0;
    if (r_state == ST_LOAD) begin
      o_mem_address = i_load_addr;
      o_mem_wren    = i_load_wren;
      o_mem_data_in = i_load_wdata;
    end else if (w_data_gnt) begin
      o_mem_address = i_data_addr;
      o_mem_wren    = i_data_wren;
      o_mem_data_in = i_data_wdata;
    end else if (w_fetch_gnt) begin
      o_mem_address = i_fetch_addr;
    end
  end

  // Starvation count: consecutive cycles fetch waited behind data, saturating at the limit.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_fetch_gnt || !i_fetch_req) begin
      w_starve_nxt = '0;
    end else if (w_data_gnt && (r_starve_cnt < LIMIT)) begin
      w_starve_nxt = r_starve_cnt + 1'b1;
    end
  end

  // Remember who issued this cycle's read so next cycle's data is routed back to it.
  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_data_gnt && !i_data_wren) begin
      w_owner_nxt = OWN_DATA;
    end else if (w_fetch_gnt) begin
      w_owner_nxt = OWN_FETCH;
    end
  end

  // Counter and response-owner registers; reset drops any read still in flight.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_starve_cnt <= '0;
      r_owner      <= OWN_NONE;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_owner      <= w_owner_nxt;
    end
  end

  // Hold registers keep each requester's last word while the other side is served.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_fetch_rdata <= '0;
      r_data_rdata  <= '0;
    end else begin
      if (r_owner == OWN_FETCH) begin
        r_fetch_rdata <= i_mem_data_out;
      end
      if (r_owner == OWN_DATA) begin
        r_data_rdata <= i_mem_data_out;
      end
    end
  end

  // Response outputs: the owning side sees the memory word directly in its response cycle.
  always_comb begin
    o_fetch_rvalid = (r_owner == OWN_FETCH);
    o_data_rvalid  = (r_owner == OWN_DATA);
    o_fetch_rdata  = o_fetch_rvalid ? i_mem_data_out : r_fetch_rdata;
    o_data_rdata   = o_data_rvalid  ? i_mem_data_out : r_data_rdata;
  end

endmodule
